// File: rtl/seq_mult_signed.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH cycles per operation,
// with per-operation signed/unsigned mode and valid/ready handshakes on both sides.
module seq_mult_signed #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [AW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   sum_c;
  logic [AW-1:0]    acc_next_c;
  logic [PW-1:0]    res_c;

  // Operand magnitudes, one add-and-shift step, and the sign-corrected result
  always_comb begin
    mag_a_c    = (signed_mode && a[WIDTH-1]) ? WIDTH'(~a + WIDTH'(1)) : a;
    mag_b_c    = (signed_mode && b[WIDTH-1]) ? WIDTH'(~b + WIDTH'(1)) : b;
    sum_c      = {1'b0, acc[AW-2:WIDTH]} + {1'b0, mcand};
    acc_next_c = mplier[0] ? ({sum_c, acc[WIDTH-1:0]} >> 1) : (acc >> 1);
    res_c      = neg ? PW'(~acc_next_c[PW-1:0] + PW'(1)) : acc_next_c[PW-1:0];
  end

  // Control FSM and datapath registers; the add uses the carry bit before each shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= mag_a_c;
            mplier   <= mag_b_c;
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          acc    <= acc_next_c;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state     <= S_DONE;
            product   <= res_c;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_signed.sv
// Directed bench for seq_mult_signed at WIDTH=8 plus sweeps at WIDTH=4 (exhaustive) and WIDTH=16.
module tb_seq_mult_signed;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv4 = 0, ir4, sm4 = 0, ov4, or4 = 0, bz4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;

  logic        iv8 = 0, ir8, sm8 = 0, ov8, or8 = 0, bz8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  logic        iv16 = 0, ir16, sm16 = 0, ov16, or16 = 0, bz16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;

  int n_cmp = 0;
  int n_err = 0;

  seq_mult_signed #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(bz4));

  seq_mult_signed #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bz8));

  seq_mult_signed #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(bz16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input int w);
    case (w)
      4:       return ov4;
      8:       return ov8;
      default: return ov16;
    endcase
  endfunction

  function automatic logic [1:0] get_bz_ir(input int w);
    case (w)
      4:       return {bz4, ir4};
      8:       return {bz8, ir8};
      default: return {bz16, ir16};
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      4:       return {24'b0, p4};
      8:       return {16'b0, p8};
      default: return p16;
    endcase
  endfunction

  task automatic drive(input int w, input logic [15:0] ia, input logic [15:0] ib,
                       input logic sm, input logic iv);
    case (w)
      4:       begin a4 = ia[3:0]; b4 = ib[3:0]; sm4 = sm; iv4 = iv; end
      8:       begin a8 = ia[7:0]; b8 = ib[7:0]; sm8 = sm; iv8 = iv; end
      default: begin a16 = ia; b16 = ib; sm16 = sm; iv16 = iv; end
    endcase
  endtask

  task automatic set_or(input int w, input logic v);
    case (w)
      4:       or4 = v;
      8:       or8 = v;
      default: or16 = v;
    endcase
  endtask

  // Full operation from IDLE: accept, latency, product, result handshake
  task automatic run_op(input int w, input logic [15:0] ia, input logic [15:0] ib,
                        input logic sm, input logic [31:0] exp, input string tag);
    int lat;
    drive(w, ia, ib, sm, 1'b1);
    @(posedge clk); #1;
    drive(w, ~ia, ~ib, ~sm, 1'b0);
    chk({tag, "/busy_ready"}, 64'(get_bz_ir(w)), 64'(2'b10));
    lat = 0;
    while (!get_ov(w) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'(w));
    chk({tag, "/product"}, 64'(get_prod(w)), 64'(exp));
    set_or(w, 1'b1);
    @(posedge clk); #1;
    set_or(w, 1'b0);
    chk({tag, "/idle"}, 64'({get_ov(w), get_bz_ir(w)}), 64'(3'b001));
  endtask

  initial begin
    int          lat;
    int          idx;
    int          cyc [3];
    logic [15:0] ep  [3];
    logic [3:0]  va, vb;
    logic [7:0]  e8;
    logic [15:0] r1, r2;
    logic [31:0] e32;
    longint      pa, pb;
    int          ia, ib;

    cyc = '{8, 18, 28};
    ep  = '{16'd15, 16'd0, 16'd0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset/out_valid", 64'(ov8), 64'(0));
    chk("reset/in_ready", 64'(ir8), 64'(1));
    chk("reset/busy", 64'(bz8), 64'(0));
    chk("reset/product", 64'(p8), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned and signed corner products
    run_op(8, 16'd255, 16'd255, 1'b0, 32'hFE01, "u255x255");
    run_op(8, 16'h80, 16'h80, 1'b1, 32'h4000, "s_m128sq");
    run_op(8, 16'hFF, 16'h7F, 1'b1, 32'hFF81, "s_m1x127");
    run_op(8, 16'h80, 16'h01, 1'b1, 32'hFF80, "s_m128x1");
    run_op(8, 16'h80, 16'h80, 1'b0, 32'h4000, "u128x128");
    run_op(8, 16'h00, 16'hFF, 1'b1, 32'h0000, "s_zero");
    run_op(8, 16'hF6, 16'h0A, 1'b1, 32'hFF9C, "s_m10x10");
    run_op(8, 16'hF6, 16'h0A, 1'b0, 32'h099C, "u246x10");

    // Backpressure: result held, new operands ignored
    drive(8, 16'd7, 16'd9, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8, 16'd0, 16'd0, 1'b0, 1'b0);
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp/latency", 64'(lat), 64'(8));
    chk("bp/product", 64'(p8), 64'(63));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(8, 16'd50, 16'd50, 1'b0, i == 1);
      chk("bp/hold_valid", 64'(ov8), 64'(1));
      chk("bp/hold_product", 64'(p8), 64'(63));
      chk("bp/hold_ready", 64'(ir8), 64'(0));
    end
    drive(8, 16'd0, 16'd0, 1'b0, 1'b0);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("bp/release_valid", 64'(ov8), 64'(0));
    chk("bp/release_ready", 64'(ir8), 64'(1));
    chk("bp/retained_product", 64'(p8), 64'(63));
    @(posedge clk); #1;
    chk("bp/no_queued_op", 64'(bz8), 64'(0));

    // Reset during RUN cycle 4
    drive(8, 16'd100, 16'd100, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort/out_valid", 64'(ov8), 64'(0));
    chk("abort/in_ready", 64'(ir8), 64'(1));
    chk("abort/busy", 64'(bz8), 64'(0));
    chk("abort/product", 64'(p8), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8, 16'd12, 16'hFD, 1'b1, 32'hFFDC, "after_abort");

    // Back-to-back with in_valid and out_ready tied high
    drive(8, 16'd3, 16'd5, 1'b0, 1'b1);
    or8 = 1'b1;
    @(posedge clk); #1;
    drive(8, 16'd0, 16'd200, 1'b0, 1'b1);
    idx = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (ov8) begin
        if (idx < 3) begin
          chk("b2b/cycle", 64'(c), 64'(cyc[idx]));
          chk("b2b/product", 64'(p8), 64'(ep[idx]));
        end
        idx++;
        if (idx == 2) drive(8, 16'd200, 16'd0, 1'b0, 1'b1);
        if (idx == 3) drive(8, 16'd0, 16'd0, 1'b0, 1'b0);
      end
    end
    chk("b2b/count", 64'(idx), 64'(3));
    or8 = 1'b0;
    @(posedge clk); #1;

    // WIDTH=4 exhaustive, both modes
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          va = 4'(x);
          vb = 4'(y);
          ia = (m == 1) ? int'($signed(va)) : int'(va);
          ib = (m == 1) ? int'($signed(vb)) : int'(vb);
          e8 = 8'(ia * ib);
          run_op(4, {12'b0, va}, {12'b0, vb}, m == 1, {24'b0, e8}, "w4");
        end
      end
    end

    // WIDTH=16 corners and random vectors
    run_op(16, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "w16_m32768sq");
    run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "w16_umax");
    run_op(16, 16'hFFFF, 16'h7FFF, 1'b1, 32'hFFFF_8001, "w16_m1xmax");
    for (int i = 0; i < 40; i++) begin
      r1 = 16'($urandom);
      r2 = 16'($urandom);
      pa = (i % 2 == 1) ? longint'($signed(r1)) : longint'(r1);
      pb = (i % 2 == 1) ? longint'($signed(r2)) : longint'(r2);
      e32 = 32'(pa * pb);
      run_op(16, r1, r2, i % 2 == 1, e32, "w16_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
